rx_dsp_integ_dump: RTL and testbench
====================================

# rx_dsp_integ_dump

Custom RX DSP stage, plugged into the RX glue slot via `RX_DSP0_MODULE`/`RX_DSP1_MODULE`; it is the receive-side counterpart of the TX DSP glue. Frontend samples pass to the DDC unchanged. Strobed DDC output samples are integrated and dumped over 2^N samples, giving a further power-of-two decimation with an averaged output before baseband framing. N is set over the user settings bus.

## Interface
Parameters:
- `WIDTH`, 24: frontend bus width.
- `BASE`, 0: settings-bus address of the control register.

Ports:
- `clock`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous flush of the accumulator and counter.
- `enable`  in  1  stream enable.
- `set_stb`  in  1  settings strobe.
- `set_addr`  in  8  settings address.
- `set_data`  in  32  settings data.
- `frontend_i`, `frontend_q`  in  WIDTH  full-rate samples from the RX frontend.
- `ddc_in_i`, `ddc_in_q`  out  WIDTH  full-rate samples to the DDC.
- `ddc_in_enable`  out  1  DDC enable.
- `ddc_out_sample`  in  32  {I16,Q16} from the DDC.
- `ddc_out_strobe`  in  1  DDC sample valid.
- `ddc_out_enable`  in  1  DDC running.
- `bb_sample`  out  32  {I16,Q16} to the RX framer.
- `bb_strobe`  out  1  baseband sample valid.
- `debug`  out  32  {count[7:0], log2_active[2:0], 21'b0}.

## Operation
- Combinational pass-throughs:
  - `ddc_in_i/q` = `frontend_i/q`.
  - `ddc_in_enable` = `enable`.
- Control register: a write with `set_stb` and `set_addr==BASE` loads `log2_pend <= set_data[2:0]`, giving N = 0..7 and 1..128 samples per output.
- State machine `IDLE`/`ACCUM`:
  - IDLE → ACCUM on the first `ddc_out_strobe` while `enable && ddc_out_enable`.
    - On that transition, `log2_active <= log2_pend`.
    - The accumulator is loaded with the sample (not added).
    - `count <= 1`.
  - In ACCUM, each qualifying strobe adds sign-extended I and Q to the 23-bit signed accumulators `acc_i`/`acc_q` and increments `count`.
  - When the strobe that makes `count == 2^log2_active` arrives:
    - The result is computed from the accumulator plus that sample.
    - `bb_sample` is registered and `bb_strobe` pulses for 1 cycle.
    - The FSM returns to IDLE.
    - If another strobe arrives on the next cycle, IDLE accepts it normally, so back-to-back blocks lose nothing.
  - N=0: every strobe produces an output directly from IDLE; the FSM never enters ACCUM.
- Result:
  - Computed as (acc + round) >>> N (arithmetic shift), then the low 16 bits.
  - A full-scale block average never exceeds ±32767/−32768, so no saturation logic is needed.
- Settings written mid-block take effect only at the next IDLE → ACCUM.
- `clear`, or `enable` low:
  - Returns the FSM to IDLE and zeroes the accumulators and `count`.
  - Suppresses `bb_strobe` that cycle.
  - Retains `log2_pend`.
- A strobe coincident with `clear` is discarded.
- `ddc_out_enable` low: strobes are ignored and the state holds.

## Timing
- Reset values:
  - `bb_sample` = 0, `bb_strobe` = 0, `debug` = 0.
  - State IDLE, `log2_pend` = 0, `log2_active` = 0.
- Latency: `bb_strobe` asserts exactly one cycle after the final `ddc_out_strobe` of a block.
- `bb_sample` holds its value between strobes.
- No backpressure: the downstream side must accept every `bb_strobe`.
- `reset_n` asserted mid-block aborts the block immediately; no partial output is produced.

## Configuration
- `RX_INTEG_ROUND_EN` defined: round = 2^(N−1) when N>0, otherwise 0 (round half up).
- Undefined: round = 0, so the result is truncated toward −∞.
- The pass-through paths are identical in both builds.

## Structure
- Shared package `rx_dsp_pkg`:
  - State enum `{IDLE, ACCUM}`.
  - `ACC_W = 23`.
  - `LOG2_MAX = 7`.
  - Control-register field offsets.
- One sub-module, `integ_dump_lane`: a 16-bit-in, 23-bit accumulate, round/shift, 16-bit-out lane, instantiated for I and for Q.
- Control FSM and settings register live in the top.

## Test plan
- Reset, N=0, strobe {I=100, Q=−100}: `bb_strobe` one cycle later with `bb_sample` = {100, −100}; outputs 0 before the first strobe.
- N=2, four strobes I = 1, 2, 3, 4: `bb_sample` I = 3 with rounding (10+2 = 12, >>2), I = 2 without; exactly one `bb_strobe`.
- N=7, 128 strobes at I=32767 and then at I=−32768: outputs 32767 and −32768 exactly, no wrap.
- N=3 with `clear` after the 5th strobe, then 8 strobes of I=8: a single output I=8; no output from the partial block.
- Write N=1 during an N=2 block: the current block completes with 4 samples and the next block uses 2.
- Continuous strobes on every cycle at N=1: `bb_strobe` every 2nd cycle; no dropped samples across 100 blocks.

Source files
------------

// File: rtl/rx_dsp_pkg.sv
// Shared types and constants for the RX integrate-and-dump DSP stage.
package rx_dsp_pkg;

   typedef enum logic {IDLE, ACCUM} integ_state_t;

   localparam int ACC_W         = 23;
   localparam int LOG2_MAX      = 7;
   localparam int CNT_W         = 8;
   localparam int SAMP_W        = 16;
   localparam int CTRL_LOG2_LSB = 0;
   localparam int CTRL_LOG2_W   = 3;

endpackage

// File: rtl/integ_dump_lane.sv
// One integrate-and-dump lane: 16-bit in, 23-bit accumulate, round/shift, 16-bit out.
// Rounding (half up) is enabled by defining RX_INTEG_ROUND_EN; otherwise the result truncates.
module integ_dump_lane
   import rx_dsp_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              accept,
   input  logic              start,
   input  logic              dump,
   input  logic [2:0]        shift,
   input  logic [SAMP_W-1:0] sample,
   output logic [SAMP_W-1:0] result
);

   logic signed [ACC_W-1:0] acc_reg;
   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W:0]   round_val;
   logic signed [ACC_W:0]   rounded;

   // First sample of a block loads rather than adds.
   assign sum = (start ? '0 : acc_reg) + {{(ACC_W-SAMP_W){sample[SAMP_W-1]}}, sample};

`ifdef RX_INTEG_ROUND_EN
   assign round_val = (shift == 3'd0) ? '0 : ({{ACC_W{1'b0}}, 1'b1} << (shift - 3'd1));
`else
   assign round_val = '0;
`endif

   assign rounded = $signed({sum[ACC_W-1], sum}) + round_val;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acc_reg <= '0;
         result  <= '0;
      end else if (flush) begin
         acc_reg <= '0;
      end else if (accept) begin
         acc_reg <= dump ? '0 : sum;
         if (dump) begin
            result <= SAMP_W'(rounded >>> shift);
         end
      end
   end

endmodule

// File: rtl/rx_dsp_integ_dump.sv
// RX DSP stage: frontend passes straight to the DDC; DDC output is averaged over 2^N strobes.
// Build option RX_INTEG_ROUND_EN selects round-half-up instead of truncation in the lanes.
module rx_dsp_integ_dump
   import rx_dsp_pkg::*;
#(
   parameter int         WIDTH = 24,
   parameter logic [7:0] BASE  = 8'd0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             enable,
   input  logic             set_stb,
   input  logic [7:0]       set_addr,
   input  logic [31:0]      set_data,
   input  logic [WIDTH-1:0] frontend_i,
   input  logic [WIDTH-1:0] frontend_q,
   output logic [WIDTH-1:0] ddc_in_i,
   output logic [WIDTH-1:0] ddc_in_q,
   output logic             ddc_in_enable,
   input  logic [31:0]      ddc_out_sample,
   input  logic             ddc_out_strobe,
   input  logic             ddc_out_enable,
   output logic [31:0]      bb_sample,
   output logic             bb_strobe,
   output logic [31:0]      debug
);

   integ_state_t   state_reg, state_next;
   logic [CNT_W-1:0] count_reg;
   logic [2:0]     log2_pend_reg;
   logic [2:0]     log2_active_reg;
   logic [2:0]     shift_sel;
   logic           flush, qualify, block_end;
   logic           start, accept, dump;
   logic           unused_set_data;

   assign ddc_in_i      = frontend_i;
   assign ddc_in_q      = frontend_q;
   assign ddc_in_enable = enable;

   assign flush     = clear || !enable;
   assign qualify   = ddc_out_strobe && ddc_out_enable && !flush;
   assign block_end = (count_reg + 8'd1) == (8'd1 << log2_active_reg);
   // From IDLE the pending N governs (it becomes active on this same edge).
   assign shift_sel = (state_reg == IDLE) ? log2_pend_reg : log2_active_reg;

   assign debug           = {count_reg, log2_active_reg, 21'b0};
   assign unused_set_data = ^set_data[31:CTRL_LOG2_LSB+CTRL_LOG2_W];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      start      = 1'b0;
      accept     = 1'b0;
      dump       = 1'b0;
      if (flush) begin
         state_next = IDLE;
      end else if (qualify) begin
         accept = 1'b1;
         case (state_reg)
            IDLE: begin
               start = 1'b1;
               if (log2_pend_reg == 3'd0) dump = 1'b1;
               else                       state_next = ACCUM;
            end
            ACCUM: begin
               if (block_end) begin
                  dump       = 1'b1;
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_reg       <= '0;
         log2_pend_reg   <= '0;
         log2_active_reg <= '0;
         bb_strobe       <= 1'b0;
      end else begin
         bb_strobe <= dump;
         if (set_stb && set_addr == BASE) begin
            log2_pend_reg <= set_data[CTRL_LOG2_LSB +: CTRL_LOG2_W];
         end
         if (accept && start) begin
            log2_active_reg <= log2_pend_reg;
         end
         if (flush)       count_reg <= '0;
         else if (accept) count_reg <= dump ? '0 : (start ? 8'd1 : count_reg + 8'd1);
      end
   end

   // Lane 0 handles Q (low half), lane 1 handles I (high half).
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_lane
         integ_dump_lane u_lane (
            .clock   (clock),
            .reset_n (reset_n),
            .flush   (flush),
            .accept  (accept),
            .start   (start),
            .dump    (dump),
            .shift   (shift_sel),
            .sample  (ddc_out_sample[SAMP_W*gi +: SAMP_W]),
            .result  (bb_sample[SAMP_W*gi +: SAMP_W])
         );
      end
   endgenerate

endmodule

// File: tb/tb_rx_dsp_integ_dump.sv
// Directed bench for rx_dsp_integ_dump; expected values adapt to RX_INTEG_ROUND_EN.
module tb_rx_dsp_integ_dump;

   localparam int         WIDTH = 24;
   localparam logic [7:0] BASE  = 8'h10;
`ifdef RX_INTEG_ROUND_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   logic             clock = 1'b0;
   logic             reset_n;
   logic             clear;
   logic             enable;
   logic             set_stb;
   logic [7:0]       set_addr;
   logic [31:0]      set_data;
   logic [WIDTH-1:0] frontend_i, frontend_q;
   logic [WIDTH-1:0] ddc_in_i, ddc_in_q;
   logic             ddc_in_enable;
   logic [31:0]      ddc_out_sample;
   logic             ddc_out_strobe;
   logic             ddc_out_enable;
   logic [31:0]      bb_sample;
   logic             bb_strobe;
   logic [31:0]      debug;

   int n_checks = 0;
   int n_pass   = 0;

   int          out_cnt = 0;
   int          cyc     = 0;
   logic [15:0] cap_i[$];
   int          cap_cyc[$];

   rx_dsp_integ_dump #(.WIDTH(WIDTH), .BASE(BASE)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .clear          (clear),
      .enable         (enable),
      .set_stb        (set_stb),
      .set_addr       (set_addr),
      .set_data       (set_data),
      .frontend_i     (frontend_i),
      .frontend_q     (frontend_q),
      .ddc_in_i       (ddc_in_i),
      .ddc_in_q       (ddc_in_q),
      .ddc_in_enable  (ddc_in_enable),
      .ddc_out_sample (ddc_out_sample),
      .ddc_out_strobe (ddc_out_strobe),
      .ddc_out_enable (ddc_out_enable),
      .bb_sample      (bb_sample),
      .bb_strobe      (bb_strobe),
      .debug          (debug)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      #1;
      cyc++;
      if (bb_strobe) begin
         out_cnt++;
         cap_i.push_back(bb_sample[31:16]);
         cap_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic send(input logic [15:0] i, input logic [15:0] q);
      ddc_out_sample = {i, q};
      ddc_out_strobe = 1'b1;
      @(negedge clock);
      ddc_out_strobe = 1'b0;
   endtask

   task automatic setn(input logic [2:0] n);
      set_stb  = 1'b1;
      set_addr = BASE;
      set_data = {29'h1234567, n};
      @(negedge clock);
      set_stb  = 1'b0;
   endtask

   initial begin
      int base_cnt;
      logic [15:0] exp_i;
      reset_n = 1'b0; clear = 1'b0; enable = 1'b1; set_stb = 1'b0;
      set_addr = '0; set_data = '0; frontend_i = 24'h123456; frontend_q = 24'hABCDEF;
      ddc_out_sample = '0; ddc_out_strobe = 1'b0; ddc_out_enable = 1'b1;
      repeat (3) @(negedge clock);
      check("reset_bb_sample", bb_sample, 32'd0);
      check("reset_bb_strobe", {31'd0, bb_strobe}, 32'd0);
      check("reset_debug", debug, 32'd0);
      reset_n = 1'b1;
      @(negedge clock);
      check("pass_i", {8'd0, ddc_in_i}, 32'h00123456);
      check("pass_q", {8'd0, ddc_in_q}, 32'h00ABCDEF);
      check("pass_en", {31'd0, ddc_in_enable}, 32'd1);
      check("pre_strobe_out", bb_sample, 32'd0);

      // N=0 direct output
      send(16'd100, 16'hFF9C);
      $display("txn n0: out=%h strobe=%b", bb_sample, bb_strobe);
      check("n0_strobe", {31'd0, bb_strobe}, 32'd1);
      check("n0_sample", bb_sample, {16'd100, 16'hFF9C});
      @(negedge clock);
      check("n0_single_pulse", {31'd0, bb_strobe}, 32'd0);
      check("n0_hold", bb_sample, {16'd100, 16'hFF9C});

      // N=2, one ignored strobe while ddc_out_enable is low
      setn(3'd2);
      base_cnt = out_cnt;
      send(16'd1, 16'hFFFF);
      send(16'd2, 16'hFFFE);
      ddc_out_enable = 1'b0;
      send(16'd99, 16'd99);
      ddc_out_enable = 1'b1;
      send(16'd3, 16'hFFFD);
      check("n2_debug_mid", debug, {8'd3, 3'd2, 21'd0});
      check("n2_no_early", out_cnt - base_cnt, 32'd0);
      send(16'd4, 16'hFFFC);
      $display("txn n2: out=%h strobe=%b", bb_sample, bb_strobe);
      check("n2_strobe", {31'd0, bb_strobe}, 32'd1);
      check("n2_sample", bb_sample, ROUND ? {16'd3, 16'hFFFE} : {16'd2, 16'hFFFD});
      @(negedge clock);
      check("n2_one_output", out_cnt - base_cnt, 32'd1);

      // N=7 full scale, both signs
      setn(3'd7);
      for (int k = 0; k < 128; k++) send(16'h7FFF, 16'h8000);
      $display("txn n7a: out=%h strobe=%b", bb_sample, bb_strobe);
      check("n7_pos_strobe", {31'd0, bb_strobe}, 32'd1);
      check("n7_pos_sample", bb_sample, {16'h7FFF, 16'h8000});
      for (int k = 0; k < 128; k++) send(16'h8000, 16'h7FFF);
      $display("txn n7b: out=%h strobe=%b", bb_sample, bb_strobe);
      check("n7_neg_sample", bb_sample, {16'h8000, 16'h7FFF});

      // N=3 partial block flushed by clear
      setn(3'd3);
      base_cnt = out_cnt;
      for (int k = 0; k < 5; k++) send(16'd1000, 16'd1000);
      clear = 1'b1;
      send(16'd500, 16'd500);
      clear = 1'b0;
      check("clr_debug", debug, {8'd0, 3'd3, 21'd0});
      for (int k = 0; k < 8; k++) send(16'd8, 16'hFFF8);
      $display("txn clr: out=%h strobe=%b", bb_sample, bb_strobe);
      @(negedge clock);
      check("clr_one_output", out_cnt - base_cnt, 32'd1);
      check("clr_sample", bb_sample, {16'd8, 16'hFFF8});

      // Change N mid-block: current block keeps 4 samples, next uses 2
      setn(3'd2);
      base_cnt = out_cnt;
      send(16'd4, 16'd0);
      send(16'd4, 16'd0);
      setn(3'd1);
      send(16'd4, 16'd0);
      check("midset_no_early", out_cnt - base_cnt, 32'd0);
      send(16'd4, 16'd0);
      $display("txn midset_a: out=%h strobe=%b", bb_sample, bb_strobe);
      check("midset_blk1", bb_sample, {16'd4, 16'd0});
      send(16'd6, 16'd0);
      send(16'd8, 16'd0);
      $display("txn midset_b: out=%h strobe=%b", bb_sample, bb_strobe);
      check("midset_blk2", bb_sample, {16'd7, 16'd0});
      check("midset_count", out_cnt - base_cnt, 32'd2);

      // Continuous strobes at N=1
      @(negedge clock);
      cap_i.delete();
      cap_cyc.delete();
      for (int k = 0; k < 200; k++) begin
         ddc_out_sample = {16'(k), 16'd0};
         ddc_out_strobe = 1'b1;
         @(negedge clock);
      end
      ddc_out_strobe = 1'b0;
      repeat (3) @(negedge clock);
      $display("txn stream: outputs=%0d", cap_i.size());
      check("stream_count", cap_i.size(), 32'd100);
      for (int j = 0; j < cap_i.size() && j < 100; j++) begin
         exp_i = ROUND ? 16'(2 * j + 1) : 16'(2 * j);
         check($sformatf("stream_val_%0d", j), {16'd0, cap_i[j]}, {16'd0, exp_i});
         if (j > 0) check($sformatf("stream_gap_%0d", j), cap_cyc[j] - cap_cyc[j-1], 32'd2);
      end

      // Reset mid-block aborts and clears settings
      setn(3'd2);
      base_cnt = out_cnt;
      send(16'd10, 16'd10);
      send(16'd10, 16'd10);
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check("rst_mid_debug", debug, 32'd0);
      check("rst_mid_no_out", out_cnt - base_cnt, 32'd0);
      send(16'd50, 16'd50);
      $display("txn rst: out=%h strobe=%b", bb_sample, bb_strobe);
      check("rst_n0_strobe", {31'd0, bb_strobe}, 32'd1);
      check("rst_n0_sample", bb_sample, {16'd50, 16'd50});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
